// File: rtl/clk_div_ctrl.sv
// Programmable 50%-duty clock divider with glitch-free ratio changes and clean start/stop.
// Ratio updates are deferred to the falling boundary of the divided clock.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_div_req_valid,
  input  logic [CNT_W-1:0] i_div_req_data,
  output logic             o_div_req_ready,
  output logic             o_div_err,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cur_div
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_div_err;
  logic             r_ready;
  logic             r_busy;
  logic [CNT_W-1:0] r_cur_div;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_valid;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_clk_nxt;
  logic             w_tick_nxt;
  logic             w_err_nxt;
  logic             w_ready_nxt;
  logic [CNT_W-1:0] w_cur_nxt;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             w_pend_valid_nxt;
  logic             w_accept;
  logic             w_legal;
  logic             w_wrap;

  assign w_accept = i_div_req_valid && r_ready;
  assign w_legal  = w_accept && (i_div_req_data != '0);
  assign w_wrap   = (r_cnt == (r_cur_div - CNT_W'(1)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_clk_out    <= 1'b0;
      r_tick       <= 1'b0;
      r_div_err    <= 1'b0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_cur_div    <= CNT_W'(DEFAULT_DIV);
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_clk_out    <= w_clk_nxt;
      r_tick       <= w_tick_nxt;
      r_div_err    <= w_err_nxt;
      r_ready      <= w_ready_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_cur_div    <= w_cur_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_valid <= w_pend_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_clk_nxt        = r_clk_out;
    w_tick_nxt       = 1'b0;
    w_err_nxt        = w_accept && (i_div_req_data == '0);
    w_ready_nxt      = r_ready;
    w_cur_nxt        = r_cur_div;
    w_pend_nxt       = r_pend;
    w_pend_valid_nxt = r_pend_valid;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_clk_nxt = 1'b0;
        if (w_legal) w_cur_nxt = i_div_req_data;
        if (i_en) w_state_nxt = RUN;
      end
      RUN, STOP: begin
        // Leaving for IDLE while low, or on the falling toggle: a request
        // accepted this cycle takes effect together with the IDLE entry.
        if (!i_en && (!r_clk_out || w_wrap)) begin
          w_state_nxt      = IDLE;
          w_cnt_nxt        = '0;
          w_clk_nxt        = 1'b0;
          w_ready_nxt      = 1'b1;
          w_pend_valid_nxt = 1'b0;
          if (w_legal) w_cur_nxt = i_div_req_data;
          else if (r_pend_valid) w_cur_nxt = r_pend;
        end else begin
          w_state_nxt = i_en ? RUN : STOP;
          w_cnt_nxt   = w_wrap ? '0 : r_cnt + CNT_W'(1);
          if (w_wrap) begin
            w_clk_nxt  = ~r_clk_out;
            w_tick_nxt = ~r_clk_out;
            if (r_clk_out && r_pend_valid) begin
              w_cur_nxt        = r_pend;
              w_pend_valid_nxt = 1'b0;
              w_ready_nxt      = 1'b1;
            end
          end
          if (w_legal) begin
            w_pend_nxt       = i_div_req_data;
            w_pend_valid_nxt = 1'b1;
            w_ready_nxt      = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_clk_nxt   = 1'b0;
      end
    endcase
  end

  assign o_div_req_ready = r_ready;
  assign o_div_err       = r_div_err;
  assign o_clk_out       = r_clk_out;
  assign o_tick          = r_tick;
  assign o_busy          = r_busy;
  assign o_cur_div       = r_cur_div;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed plus randomized bench for clk_div_ctrl: phase lengths are measured
// and compared with the ratio that should be in effect at each point.
module tb_clk_div_ctrl;

  logic       i_clk;
  logic       i_rst;
  logic       i_en;
  logic       i_div_req_valid;
  logic [7:0] i_div_req_data;
  logic       o_div_req_ready;
  logic       o_div_err;
  logic       o_clk_out;
  logic       o_tick;
  logic       o_busy;
  logic [7:0] o_cur_div;

  int nCompared;
  int nMismatched;
  int tickErr;
  logic prevClk;
  logic rose;
  int n, hi, lo, d, expDiv;

  clk_div_ctrl #(.CNT_W(8), .DEFAULT_DIV(5)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_en            (i_en),
    .i_div_req_valid (i_div_req_valid),
    .i_div_req_data  (i_div_req_data),
    .o_div_req_ready (o_div_req_ready),
    .o_div_err       (o_div_err),
    .o_clk_out       (o_clk_out),
    .o_tick          (o_tick),
    .o_busy          (o_busy),
    .o_cur_div       (o_cur_div)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic valid, input logic [7:0] data);
    i_en            = en;
    i_div_req_valid = valid;
    i_div_req_data  = data;
  endtask

  // One clock; tick must coincide exactly with every 0->1 of clk_out.
  task automatic step();
    @(posedge i_clk);
    #1;
    rose = o_clk_out && !prevClk;
    if (o_tick !== rose) tickErr++;
    prevClk = o_clk_out;
  endtask

  task automatic sendReq(input logic en, input logic [7:0] data);
    applyStimulus(en, 1'b1, data);
    step();
    applyStimulus(en, 1'b0, 8'd0);
  endtask

  task automatic waitRise(output int cnt);
    cnt = 0;
    while (o_clk_out !== 1'b1 && cnt < 1000) begin
      step();
      cnt++;
    end
  endtask

  // Starting inside a high phase, count remaining high samples then low samples.
  task automatic measurePhases(output int h, output int l);
    h = 0;
    l = 0;
    while (o_clk_out === 1'b1 && h < 1000) begin
      h++;
      step();
    end
    while (o_clk_out === 1'b0 && l < 1000) begin
      l++;
      step();
    end
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    tickErr = 0;
    prevClk = 1'b0;
    i_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0);
    step();
    step();
    checkOutput("rstClk", 32'(o_clk_out), 32'd0);
    checkOutput("rstTick", 32'(o_tick), 32'd0);
    checkOutput("rstErr", 32'(o_div_err), 32'd0);
    checkOutput("rstReady", 32'(o_div_req_ready), 32'd1);
    checkOutput("rstBusy", 32'(o_busy), 32'd0);
    checkOutput("rstCurDiv", 32'(o_cur_div), 32'd5);
    i_rst = 1'b0;
    expDiv = 5;

    // Default run: first rise after cur_div cycles, then 5 high / 5 low
    applyStimulus(1'b1, 1'b0, 8'd0);
    step();
    checkOutput("startBusy", 32'(o_busy), 32'd1);
    waitRise(n);
    checkOutput("firstRise", n, 5);
    measurePhases(hi, lo);
    checkOutput("defHigh", hi, 5);
    checkOutput("defLow", lo, 5);

    // Mid-high change to 3: old high completes, then 3/3
    sendReq(1'b1, 8'd3);
    checkOutput("reqReadyLow", 32'(o_div_req_ready), 32'd0);
    checkOutput("reqCurOld", 32'(o_cur_div), 32'd5);
    measurePhases(hi, lo);
    checkOutput("chgOldHigh", hi + 1, 5);
    checkOutput("chgNewLow", lo, 3);
    checkOutput("chgCurDiv", 32'(o_cur_div), 32'd3);
    checkOutput("chgReady", 32'(o_div_req_ready), 32'd1);
    measurePhases(hi, lo);
    checkOutput("newHigh", hi, 3);
    checkOutput("newLow", lo, 3);
    expDiv = 3;

    // Zero request: error pulse, nothing else changes
    sendReq(1'b1, 8'd0);
    checkOutput("zeroErr", 32'(o_div_err), 32'd1);
    checkOutput("zeroReady", 32'(o_div_req_ready), 32'd1);
    step();
    checkOutput("zeroErrOnce", 32'(o_div_err), 32'd0);
    checkOutput("zeroCurDiv", 32'(o_cur_div), 32'd3);
    measurePhases(hi, lo);
    checkOutput("zeroHigh", hi + 2, 3);
    checkOutput("zeroLow", lo, 3);

    // Randomized ratio changes made during the high phase
    for (int k = 0; k < 3; k++) begin
      d = int'($urandom_range(12, 2));
      sendReq(1'b1, 8'(d));
      measurePhases(hi, lo);
      checkOutput("rndOldHigh", hi + 1, expDiv);
      checkOutput("rndNewLow", lo, d);
      expDiv = d;
      measurePhases(hi, lo);
      checkOutput("rndHigh", hi, expDiv);
      checkOutput("rndLow", lo, expDiv);
      checkOutput("rndCurDiv", 32'(o_cur_div), expDiv);
    end

    // Falling toggle + new request + en=0 in one cycle: IDLE with new ratio
    for (int k = 0; k < expDiv - 1; k++) step();
    checkOutput("simLastHigh", 32'(o_clk_out), 32'd1);
    d = int'($urandom_range(12, 2));
    applyStimulus(1'b0, 1'b1, 8'(d));
    step();
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("simClk", 32'(o_clk_out), 32'd0);
    checkOutput("simBusy", 32'(o_busy), 32'd0);
    checkOutput("simCurDiv", 32'(o_cur_div), d);
    checkOutput("simReady", 32'(o_div_req_ready), 32'd1);

    // Load 4 in IDLE, then stop 2 cycles into high with a pending 6
    sendReq(1'b0, 8'd4);
    checkOutput("idleLoad", 32'(o_cur_div), 32'd4);
    checkOutput("idleReady", 32'(o_div_req_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    step();
    waitRise(n);
    checkOutput("rise4", n, 4);
    sendReq(1'b1, 8'd6);
    applyStimulus(1'b0, 1'b0, 8'd0);
    step();
    checkOutput("stopBusy", 32'(o_busy), 32'd1);
    checkOutput("stopClkHigh", 32'(o_clk_out), 32'd1);
    n = 0;
    while (o_clk_out === 1'b1 && n < 100) begin
      n++;
      step();
    end
    checkOutput("stopHighLen", n + 2, 4);
    checkOutput("stopIdleBusy", 32'(o_busy), 32'd0);
    checkOutput("stopPendApplied", 32'(o_cur_div), 32'd6);
    checkOutput("stopReady", 32'(o_div_req_ready), 32'd1);
    step();
    step();
    checkOutput("idleClkLow", 32'(o_clk_out), 32'd0);

    // Second run at 6: re-raise en during STOP, period stays intact
    applyStimulus(1'b1, 1'b0, 8'd0);
    step();
    waitRise(n);
    checkOutput("rise6", n, 6);
    applyStimulus(1'b0, 1'b0, 8'd0);
    step();
    applyStimulus(1'b1, 1'b0, 8'd0);
    step();
    checkOutput("resumeBusy", 32'(o_busy), 32'd1);
    measurePhases(hi, lo);
    checkOutput("resumeHigh", hi + 2, 6);
    checkOutput("resumeLow", lo, 6);

    // Stop requested during low phase: IDLE one cycle later
    while (o_clk_out === 1'b1 && n < 200) begin
      n++;
      step();
    end
    applyStimulus(1'b0, 1'b0, 8'd0);
    step();
    checkOutput("lowStopBusy", 32'(o_busy), 32'd0);
    checkOutput("lowStopClk", 32'(o_clk_out), 32'd0);

    // Divide-by-2
    sendReq(1'b0, 8'd1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    step();
    waitRise(n);
    checkOutput("rise1", n, 1);
    for (int k = 0; k < 2; k++) begin
      measurePhases(hi, lo);
      checkOutput("div2High", hi, 1);
      checkOutput("div2Low", lo, 1);
    end
    applyStimulus(1'b0, 1'b0, 8'd0);
    n = 0;
    do begin
      step();
      n++;
    end while (o_busy === 1'b1 && n < 10);
    checkOutput("div2Idle", 32'(o_busy), 32'd0);

    // Maximum half-period
    sendReq(1'b0, 8'd255);
    checkOutput("maxLoad", 32'(o_cur_div), 32'd255);
    applyStimulus(1'b1, 1'b0, 8'd0);
    step();
    waitRise(n);
    checkOutput("rise255", n, 255);
    measurePhases(hi, lo);
    checkOutput("maxHigh", hi, 255);
    checkOutput("maxLow", lo, 255);

    // Reset during high phase with a request pending
    sendReq(1'b1, 8'd9);
    checkOutput("preRstReady", 32'(o_div_req_ready), 32'd0);
    i_rst = 1'b1;
    step();
    checkOutput("midRstClk", 32'(o_clk_out), 32'd0);
    checkOutput("midRstCurDiv", 32'(o_cur_div), 32'd5);
    checkOutput("midRstReady", 32'(o_div_req_ready), 32'd1);
    checkOutput("midRstBusy", 32'(o_busy), 32'd0);
    i_rst = 1'b0;
    step();
    waitRise(n);
    checkOutput("postRstRise", n, 5);
    measurePhases(hi, lo);
    checkOutput("postRstHigh", hi, 5);
    checkOutput("postRstLow", lo, 5);

    checkOutput("tickAlign", tickErr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
